pc_sequencer: RTL and testbench

- Multicycle sequencer for the 8-bit nRisc program counter register. It computes the next PC and drives the register's write enable (SinalEscPC) and next-value (proxPC) inputs.
- Performs the instruction-memory fetch handshake and applies jump, return and branch redirection, stalls and halt.
- Initialises the PC after reset, because the PC register itself has no reset.
- Sits between the PC register, instruction memory and the main control unit.

---
 rtl/nrisc_pkg.sv | 21 ++
 rtl/pc_next_calc.sv | 43 ++++
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 tb/tb_pc_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared definitions for the nRisc program-counter sequencer.
//   ADDR_W               - instruction address width (8 bits)
//   RESET_VECTOR_DEFAULT - default address loaded into the PC after reset
//   state_t              - sequencer state encoding (3 bits)
package nrisc_pkg;

  localparam int ADDR_W = 8;

  localparam logic [ADDR_W-1:0] RESET_VECTOR_DEFAULT = 8'h00;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    FETCH = 3'd2,
    EXEC  = 3'd3,
    WRITE = 3'd4,
    HALT  = 3'd5,
    FAULT = 3'd6
  } state_t;

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC selection for the nRisc core.
//   pc            in  current PC
//   jump          in  absolute jump request (highest priority)
//   jump_target   in  absolute jump destination
//   ret           in  return request, selects link_reg
//   link_reg      in  saved return address
//   branch_taken  in  PC-relative branch request
//   branch_offset in  signed offset relative to pc+1
//   nxt           out selected next PC (modulo 256)
//   link_value    out return address to save on a linked jump (pc+1)
module pc_next_calc
  import nrisc_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              ret,
  input  logic [ADDR_W-1:0] link_reg,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] nxt,
  output logic [ADDR_W-1:0] link_value
);

  logic        [ADDR_W-1:0] pc_inc;
  logic signed [ADDR_W-1:0] offset_s;

  assign pc_inc     = pc + ADDR_W'(1);
  assign offset_s   = $signed(branch_offset);
  assign link_value = pc_inc;

  // An 8-bit add of the two's-complement offset wraps exactly like a signed add
  always_comb begin
    nxt = pc_inc;
    if (jump)
      nxt = jump_target;
    else if (ret)
      nxt = link_reg;
    else if (branch_taken)
      nxt = pc_inc + $unsigned(offset_s);
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle sequencer for the 8-bit nRisc PC register.
// Drives the PC register's write enable and next value, performs the
// instruction fetch handshake and applies jump/return/branch, stall and halt.
//   clock        in  system clock (sequencer on posedge, PC register on negedge)
//   reset        in  asynchronous active-high reset
//   start        in  leave IDLE and begin execution
//   pc_atual     in  current PC from the PC register
//   proxPC       out next PC value for the PC register
//   SinalEscPC   out PC write enable
//   imem_req     out instruction fetch request
//   imem_addr    out fetch address
//   imem_ack     in  fetch complete
//   instr_valid  out one-cycle pulse on first EXEC cycle
//   stall        in  hold in EXEC
//   jump/jump_target/link/ret/branch_taken/branch_offset in  redirect controls
//   halt         in  halt instruction decoded
//   halted       out high in HALT
//   fault        out high in FAULT (fetch timeout)
//   retired      out count of completed PC updates
module pc_sequencer
  import nrisc_pkg::*;
#(
  parameter logic [7:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int         MAX_WAIT     = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  pc_atual,
  output logic [7:0]  proxPC,
  output logic        SinalEscPC,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        jump,
  input  logic [7:0]  jump_target,
  input  logic        link,
  input  logic        ret,
  input  logic        branch_taken,
  input  logic [7:0]  branch_offset,
  input  logic        halt,
  output logic        halted,
  output logic        fault,
  output logic [15:0] retired
);

  state_t     state, state_nxt;
  logic [7:0] nxt_reg;
  logic [7:0] link_reg;
  logic [7:0] nxt_calc;
  logic [7:0] link_value;
  logic [7:0] wait_cnt;
  logic       first_exec;
  logic       timeout;
  logic       exec_advance;

  pc_next_calc u_next (
    .pc            (pc_atual),
    .jump          (jump),
    .jump_target   (jump_target),
    .ret           (ret),
    .link_reg      (link_reg),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .nxt           (nxt_calc),
    .link_value    (link_value)
  );

  // wait_cnt counts completed FETCH cycles, so it equals MAX_WAIT-1 during
  // the MAX_WAIT-th cycle; an ack in that same cycle still wins.
  assign timeout      = (wait_cnt == 8'(MAX_WAIT - 1));
  assign exec_advance = (state == EXEC) && !halt && !stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= INIT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    proxPC      = nxt_reg;
    SinalEscPC  = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = 8'h00;
    instr_valid = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    case (state)
      INIT: begin
        SinalEscPC = 1'b1;
        proxPC     = RESET_VECTOR;
        state_nxt  = IDLE;
      end
      IDLE: begin
        if (start)
          state_nxt = FETCH;
      end
      FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_atual;
        if (imem_ack)
          state_nxt = EXEC;
        else if (timeout)
          state_nxt = FAULT;
      end
      EXEC: begin
        instr_valid = first_exec;
        if (halt)
          state_nxt = HALT;
        else if (!stall)
          state_nxt = WRITE;
      end
      WRITE: begin
        SinalEscPC = 1'b1;
        state_nxt  = FETCH;
      end
      HALT:    halted = 1'b1;
      FAULT:   fault  = 1'b1;
      default: state_nxt = INIT;
    endcase
  end

  // link_reg is written after nxt_calc has already read it, so a linked jump
  // to link_reg's own address sees the old value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nxt_reg    <= RESET_VECTOR;
      link_reg   <= RESET_VECTOR;
      retired    <= 16'h0000;
      wait_cnt   <= 8'h00;
      first_exec <= 1'b0;
    end else begin
      first_exec <= (state == FETCH) && imem_ack;
      wait_cnt   <= ((state == FETCH) && !imem_ack) ? wait_cnt + 8'd1 : 8'h00;
      if (exec_advance) begin
        nxt_reg <= nxt_calc;
        if (jump && link)
          link_reg <= link_value;
      end
      if (state == WRITE)
        retired <= retired + 16'd1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam logic [7:0] RV = 8'h00;

  logic        clock = 1'b0;
  logic        reset, start, imem_ack, stall, jump, link, ret, branch_taken, halt;
  logic [7:0]  jump_target, branch_offset, pc_atual, proxPC, imem_addr;
  logic        SinalEscPC, imem_req, instr_valid, halted, fault;
  logic [15:0] retired;
  logic [7:0]  pc_reg;

  int total = 0;
  int bad   = 0;
  int m_pc, m_link, m_ret;

  always #5 clock = ~clock;

  // PC register: no reset, samples on negedge
  always @(negedge clock) if (SinalEscPC === 1'b1) pc_reg <= proxPC;
  assign pc_atual = pc_reg;

  pc_sequencer #(.RESET_VECTOR(RV), .MAX_WAIT(15)) dut (
    .clock(clock), .reset(reset), .start(start), .pc_atual(pc_atual),
    .proxPC(proxPC), .SinalEscPC(SinalEscPC), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .instr_valid(instr_valid),
    .stall(stall), .jump(jump), .jump_target(jump_target), .link(link),
    .ret(ret), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .halt(halt), .halted(halted), .fault(fault), .retired(retired)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_ctrl();
    start = 0; imem_ack = 0; stall = 0; jump = 0; link = 0; ret = 0;
    branch_taken = 0; halt = 0; jump_target = 8'h00; branch_offset = 8'h00;
  endtask

  // Reference next-PC rule: jump > ret > branch > sequential, modulo 256
  function automatic int ref_next(int pc, bit j, bit r, bit b, int jt, int off8, int lnk);
    int off;
    off = (off8 >= 128) ? off8 - 256 : off8;
    if (j) return jt;
    if (r) return lnk;
    if (b) return (pc + 1 + off + 256) % 256;
    return (pc + 1) % 256;
  endfunction

  // Reset, then start; leaves the DUT in its first FETCH cycle
  task automatic do_reset_start();
    clear_ctrl();
    reset = 1;
    #1;
    total++;
    if (SinalEscPC !== 1'b1 || proxPC !== RV || imem_req !== 1'b0 || halted !== 1'b0 ||
        fault !== 1'b0 || instr_valid !== 1'b0 || retired !== 16'h0000) begin
      bad++;
      $display("FAIL reset_outputs: wr=%b prox=%h req=%b hlt=%b flt=%b iv=%b ret=%h want 1 %h 0 0 0 0 0000",
               SinalEscPC, proxPC, imem_req, halted, fault, instr_valid, retired, RV);
    end
    tick();
    reset = 0;
    tick();
    total++;
    if (SinalEscPC !== 1'b0 || imem_req !== 1'b0 || pc_atual !== RV) begin
      bad++;
      $display("FAIL idle: wr=%b req=%b pc=%h want 0 0 %h", SinalEscPC, imem_req, pc_atual, RV);
    end
    start = 1;
    tick();
    start = 0;
    m_pc = RV; m_link = RV; m_ret = 0;
  endtask

  // One instruction from FETCH through WRITE, back in FETCH on return
  task automatic run_instr(input string tag, input int ack_dly, input int stall_n,
                           input bit j, input bit lk, input bit r, input bit b,
                           input logic [7:0] jt, input logic [7:0] off);
    int exp_nxt;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 8'(m_pc)) begin
      bad++;
      $display("FAIL %s fetch: req=%b addr=%h want 1 %h", tag, imem_req, imem_addr, 8'(m_pc));
    end
    imem_ack = 0;
    for (int i = 0; i < ack_dly; i++) tick();
    imem_ack = 1;
    tick();
    imem_ack = 0;
    total++;
    if (instr_valid !== 1'b1 || SinalEscPC !== 1'b0) begin
      bad++;
      $display("FAIL %s exec_entry: iv=%b wr=%b want 1 0", tag, instr_valid, SinalEscPC);
    end
    jump = j; link = lk; ret = r; branch_taken = b; jump_target = jt; branch_offset = off;
    stall = (stall_n > 0);
    for (int s = 0; s < stall_n; s++) begin
      tick();
      total++;
      if (instr_valid !== 1'b0 || SinalEscPC !== 1'b0 || imem_req !== 1'b0 || pc_atual !== 8'(m_pc)) begin
        bad++;
        $display("FAIL %s stall: iv=%b wr=%b req=%b pc=%h want 0 0 0 %h",
                 tag, instr_valid, SinalEscPC, imem_req, pc_atual, 8'(m_pc));
      end
    end
    stall = 0;
    tick();
    exp_nxt = ref_next(m_pc, j, r, b, int'(jt), int'(off), m_link);
    total++;
    if (SinalEscPC !== 1'b1 || proxPC !== 8'(exp_nxt)) begin
      bad++;
      $display("FAIL %s write: wr=%b prox=%h want 1 %h", tag, SinalEscPC, proxPC, 8'(exp_nxt));
    end
    jump = 0; link = 0; ret = 0; branch_taken = 0;
    tick();
    if (j && lk) m_link = (m_pc + 1) % 256;
    m_pc  = exp_nxt;
    m_ret = (m_ret + 1) % 65536;
    total++;
    if (retired !== 16'(m_ret)) begin
      bad++;
      $display("FAIL %s retired: got %0d want %0d", tag, retired, m_ret);
    end
  endtask

  task automatic test_reset();
    do_reset_start();
  endtask

  task automatic test_sequential();
    run_instr("seq0", 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    run_instr("seq1", 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    total++;
    if (retired !== 16'd2 || pc_atual !== 8'h02) begin
      bad++;
      $display("FAIL seq_state: retired=%0d pc=%h want 2 02", retired, pc_atual);
    end
  endtask

  task automatic test_jump_link_ret();
    run_instr("jmp05", 0, 0, 1, 0, 0, 0, 8'h05, 8'h00);
    run_instr("jal40", 0, 0, 1, 1, 0, 0, 8'h40, 8'h00);
    run_instr("seq41", 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    run_instr("seq42", 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    run_instr("ret06", 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
    total++;
    if (pc_atual !== 8'h06) begin
      bad++;
      $display("FAIL ret_pc: got %h want 06", pc_atual);
    end
  endtask

  task automatic test_branch_wrap();
    run_instr("jmp02", 0, 0, 1, 0, 0, 0, 8'h02, 8'h00);
    run_instr("brFC", 0, 0, 0, 0, 0, 1, 8'h00, 8'hFC);
    run_instr("wrap", 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    total++;
    if (pc_atual !== 8'h00) begin
      bad++;
      $display("FAIL wrap_pc: got %h want 00", pc_atual);
    end
  endtask

  task automatic test_stall();
    run_instr("stall4", 0, 4, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic test_late_ack();
    run_instr("ack15", 14, 0, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_instr("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                ($urandom % 4) == 0, ($urandom % 2) == 0, ($urandom % 4) == 0,
                ($urandom % 3) == 0, 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_fault();
    imem_ack = 0;
    for (int i = 0; i < 14; i++) tick();
    total++;
    if (fault !== 1'b0 || imem_req !== 1'b1) begin
      bad++;
      $display("FAIL fault_early: fault=%b req=%b want 0 1", fault, imem_req);
    end
    tick();
    total++;
    if (fault !== 1'b1 || imem_req !== 1'b0 || SinalEscPC !== 1'b0) begin
      bad++;
      $display("FAIL fault_entry: fault=%b req=%b wr=%b want 1 0 0", fault, imem_req, SinalEscPC);
    end
    imem_ack = 1;
    for (int i = 0; i < 3; i++) tick();
    imem_ack = 0;
    total++;
    if (fault !== 1'b1 || pc_atual !== 8'(m_pc)) begin
      bad++;
      $display("FAIL fault_hold: fault=%b pc=%h want 1 %h", fault, pc_atual, 8'(m_pc));
    end
  endtask

  task automatic test_halt();
    do_reset_start();
    run_instr("pre_halt", 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    imem_ack = 1;
    tick();
    imem_ack = 0;
    halt = 1; jump = 1; jump_target = 8'h77;
    tick();
    total++;
    if (halted !== 1'b1 || SinalEscPC !== 1'b0) begin
      bad++;
      $display("FAIL halt_entry: halted=%b wr=%b want 1 0", halted, SinalEscPC);
    end
    halt = 0; jump = 0; start = 1;
    for (int i = 0; i < 3; i++) tick();
    start = 0;
    total++;
    if (halted !== 1'b1 || pc_atual !== 8'(m_pc) || retired !== 16'(m_ret)) begin
      bad++;
      $display("FAIL halt_hold: halted=%b pc=%h ret=%0d want 1 %h %0d",
               halted, pc_atual, retired, 8'(m_pc), m_ret);
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset_start();
    run_instr("pre_rst", 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    imem_ack = 0;
    tick();
    tick();
    #2;
    reset = 1;
    #1;
    total++;
    if (SinalEscPC !== 1'b1 || proxPC !== RV || imem_req !== 1'b0 || retired !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mid_fetch: wr=%b prox=%h req=%b ret=%0d want 1 %h 0 0",
               SinalEscPC, proxPC, imem_req, retired, RV);
    end
    tick();
    reset = 0;
    tick();
    total++;
    if (SinalEscPC !== 1'b0 || pc_atual !== RV) begin
      bad++;
      $display("FAIL reset_recover: wr=%b pc=%h want 0 %h", SinalEscPC, pc_atual, RV);
    end
  endtask

  initial begin
    clear_ctrl();
    reset = 1;
    #12;
    test_reset();
    test_sequential();
    test_jump_link_ret();
    test_branch_wrap();
    test_stall();
    test_late_ack();
    test_random();
    test_fault();
    test_halt();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
